// File: rtl/bg_sdram_arbiter.sv
// Arbitrates the SDRAM port between background download writes and pixel prefetch reads.
// Optional BG_UNDERFLOW_STATS_EN adds a saturating underflow_cnt output.
module bg_sdram_arbiter #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FRAME_BYTES = 614400
) (
  input  logic              clk_mem,
  input  logic              RESET_L,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  output logic              underflow,
`ifdef BG_UNDERFLOW_STATS_EN
  output logic [15:0]       underflow_cnt,
`endif
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [15:0]       sd_dout,
  input  logic              sd_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]   DepthC   = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FrameEnd = ADDR_W'(FRAME_BYTES - 2);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StWait} state_e;

  state_e            state_q;
  logic              skid_full_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic [7:0]        skid_data_q;
  logic              drop_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              fetch_en_q;
  logic              epoch_q;
  logic              rd_epoch_q;
  logic              op_is_rd_q;
  logic              seen_low_q;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [15:0]       last_q;
  logic              underflow_q;

  logic fifo_empty, do_pop, do_push, rd_done, skid_clear, pop_empty;

  always_comb begin
    fifo_empty = (count_q == '0);
    do_pop     = pix_pop && !fifo_empty;
    pop_empty  = pix_pop && fifo_empty;
    rd_done    = (state_q == StWait) && op_is_rd_q && seen_low_q && sd_ready;
    // Reads tagged with a stale epoch belong to a previous frame and are dropped.
    do_push    = rd_done && (rd_epoch_q == epoch_q) && !frame_start;
    skid_clear = (state_q == StWr) && sd_ready;
  end

  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_empty ? last_q : mem[rd_ptr_q];
  assign underflow = underflow_q;

  always_ff @(posedge clk_mem) begin
    if (do_push) mem[wr_ptr_q] <= sd_dout;
  end

  always_ff @(posedge clk_mem or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (do_pop) last_q <= mem[rd_ptr_q];
      if (frame_start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
        else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
      end
      if (frame_start)    underflow_q <= 1'b0;
      else if (pop_empty) underflow_q <= 1'b1;
    end
  end

`ifdef BG_UNDERFLOW_STATS_EN
  always_ff @(posedge clk_mem or negedge RESET_L) begin
    if (!RESET_L) begin
      underflow_cnt <= '0;
    end else if (pop_empty && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk_mem or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q      <= StIdle;
      skid_full_q  <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      drop_q       <= 1'b0;
      fetch_addr_q <= '0;
      fetch_en_q   <= 1'b0;
      epoch_q      <= 1'b0;
      rd_epoch_q   <= 1'b0;
      op_is_rd_q   <= 1'b0;
      seen_low_q   <= 1'b0;
      sd_addr      <= '0;
      sd_din       <= '0;
      sd_we        <= 1'b0;
      sd_rd        <= 1'b0;
    end else begin
      sd_we <= 1'b0;
      sd_rd <= 1'b0;

      if (dl_wr) begin
        if (skid_full_q && !skid_clear) drop_q <= 1'b1;
        skid_full_q <= 1'b1;
        skid_addr_q <= dl_addr;
        skid_data_q <= dl_data;
      end else if (skid_clear) begin
        skid_full_q <= 1'b0;
      end

      // Fetching stays off after a download until the next frame boundary.
      if (dl_active)        fetch_en_q <= 1'b0;
      else if (frame_start) fetch_en_q <= 1'b1;

      if (frame_start) begin
        epoch_q      <= ~epoch_q;
        fetch_addr_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (skid_full_q) state_q <= StWr;
          else if (!dl_active && fetch_en_q && (count_q < DepthC)) state_q <= StRd;
        end
        StWr: begin
          if (sd_ready) begin
            sd_we      <= 1'b1;
            sd_addr    <= skid_addr_q;
            sd_din     <= skid_data_q;
            op_is_rd_q <= 1'b0;
            seen_low_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StRd: begin
          if (skid_full_q || dl_active || !fetch_en_q) begin
            state_q <= StIdle;
          end else if (sd_ready) begin
            sd_rd      <= 1'b1;
            sd_addr    <= fetch_addr_q;
            rd_epoch_q <= epoch_q;
            op_is_rd_q <= 1'b1;
            seen_low_q <= 1'b0;
            state_q    <= StWait;
            if (!frame_start) begin
              fetch_addr_q <= (fetch_addr_q == FrameEnd) ? '0 : fetch_addr_q + ADDR_W'(2);
            end
          end
        end
        StWait: begin
          if (!sd_ready)       seen_low_q <= 1'b1;
          else if (seen_low_q) state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A download byte overwriting an unissued one means the ioctl pacing assumption broke.
  a_no_drop: assert property (@(posedge clk_mem) disable iff (!RESET_L)
                              !(dl_wr && skid_full_q && !skid_clear));

endmodule

// File: tb/tb_bg_sdram_arbiter.sv
// Directed bench for bg_sdram_arbiter with a latency-programmable SDRAM model.
module tb_bg_sdram_arbiter;

  localparam int AW    = 25;
  localparam int DEPTH = 8;
  localparam int FRAME = 32;

  logic          clk_mem = 1'b0;
  logic          RESET_L = 1'b0;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          frame_start = 1'b0;
  logic          pix_pop = 1'b0;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          underflow;
  logic [AW-1:0] sd_addr;
  logic [7:0]    sd_din;
  logic          sd_we;
  logic          sd_rd;
  logic [15:0]   sd_dout;
  logic          sd_ready;
`ifdef BG_UNDERFLOW_STATS_EN
  logic [15:0]   underflow_cnt;
`endif

  bg_sdram_arbiter #(
    .ADDR_W      (AW),
    .FIFO_DEPTH  (DEPTH),
    .FRAME_BYTES (FRAME)
  ) dut (
    .clk_mem       (clk_mem),
    .RESET_L       (RESET_L),
    .dl_active     (dl_active),
    .dl_wr         (dl_wr),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .frame_start   (frame_start),
    .pix_pop       (pix_pop),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .underflow     (underflow),
`ifdef BG_UNDERFLOW_STATS_EN
    .underflow_cnt (underflow_cnt),
`endif
    .sd_addr       (sd_addr),
    .sd_din        (sd_din),
    .sd_we         (sd_we),
    .sd_rd         (sd_rd),
    .sd_dout       (sd_dout),
    .sd_ready      (sd_ready)
  );

  always #5 clk_mem = ~clk_mem;

  // SDRAM model: busy for lat cycles after a strobe; read data = 0x1000 + address.
  int            lat = 4;
  logic          force_busy = 1'b0;
  logic          busy;
  int            lat_cnt;
  logic [AW-1:0] cur_addr;
  logic          cur_rd;
  int            strobe_err = 0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] we_addr_log[$];
  logic [7:0]    we_data_log[$];
  logic          ev_is_we[$];
  logic [AW-1:0] ev_addr[$];

  always @(posedge clk_mem or negedge RESET_L) begin
    if (!RESET_L) begin
      sd_ready <= 1'b1;
      sd_dout  <= '0;
      busy     <= 1'b0;
      lat_cnt  <= 0;
      cur_addr <= '0;
      cur_rd   <= 1'b0;
    end else begin
      if ((sd_we || sd_rd) && !sd_ready) strobe_err <= strobe_err + 1;
      if (sd_we) begin
        we_addr_log.push_back(sd_addr);
        we_data_log.push_back(sd_din);
        ev_is_we.push_back(1'b1);
        ev_addr.push_back(sd_addr);
      end
      if (sd_rd) begin
        rd_log.push_back(sd_addr);
        ev_is_we.push_back(1'b0);
        ev_addr.push_back(sd_addr);
      end
      if (busy) begin
        if (lat_cnt <= 1) begin
          busy     <= 1'b0;
          sd_ready <= 1'b1;
          if (cur_rd) sd_dout <= 16'h1000 + 16'(cur_addr);
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end else if (sd_we || sd_rd) begin
        busy     <= 1'b1;
        sd_ready <= 1'b0;
        lat_cnt  <= lat;
        cur_addr <= sd_addr;
        cur_rd   <= sd_rd;
      end else begin
        sd_ready <= !force_busy;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_mem);
  endtask

  task automatic pulse_frame();
    @(negedge clk_mem);
    frame_start = 1'b1;
    @(negedge clk_mem);
    frame_start = 1'b0;
  endtask

  task automatic pulse_pop();
    @(negedge clk_mem);
    pix_pop = 1'b1;
    @(negedge clk_mem);
    pix_pop = 1'b0;
  endtask

  task automatic dl_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk_mem);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    @(negedge clk_mem);
    dl_wr   = 1'b0;
  endtask

  // Pops n words, checking they are the consecutive pixels starting at address 0.
  task automatic pop_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_mem);
      check_eq({tag, "_valid"}, 32'(pix_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(pix_data), 32'(16'h1000 + 16'(2 * i)));
      pix_pop = 1'b1;
    end
    @(negedge clk_mem);
    pix_pop = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input int start);
    int k = 0;
    while (rd_log.size() <= start && k < 60) begin
      @(negedge clk_mem);
      k++;
    end
    if (rd_log.size() <= start) check_eq({tag, "_rd_timeout"}, 32'd0, 32'd1);
  endtask

  logic [7:0] wdat [3];
  int mark;
  int found;

  initial begin
    wdat[0] = 8'hA5;
    wdat[1] = 8'h5A;
    wdat[2] = 8'hFF;

    // Reset state
    tick(3);
    check_eq("rst_sd_we", 32'(sd_we), 32'd0);
    check_eq("rst_sd_rd", 32'(sd_rd), 32'd0);
    check_eq("rst_sd_addr", 32'(sd_addr), 32'd0);
    check_eq("rst_sd_din", 32'(sd_din), 32'd0);
    check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("rst_pix_data", 32'(pix_data), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    RESET_L = 1'b1;
    tick(2);

    // 1: download writes, no reads
    dl_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dl_write(AW'(i), wdat[i]);
      tick(6);
    end
    tick(20);
    check_eq("t1_we_count", 32'(we_addr_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < we_addr_log.size(); i++) begin
      check_eq("t1_we_addr", 32'(we_addr_log[i]), 32'(i));
      check_eq("t1_we_data", 32'(we_data_log[i]), 32'(wdat[i]));
    end
    check_eq("t1_rd_count", 32'(rd_log.size()), 32'd0);

    // 2: prefetch fills the FIFO then stalls
    dl_active = 1'b0;
    tick(2);
    pulse_frame();
    tick(150);
    check_eq("t2_rd_count", 32'(rd_log.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < rd_log.size(); i++)
      check_eq("t2_rd_addr", 32'(rd_log[i]), 32'(2 * i));
    check_eq("t2_pix_valid", 32'(pix_valid), 32'd1);
    check_eq("t2_pix_head", 32'(pix_data), 32'h1000);

    // 3: drain faster than refill -> underflow, cleared by frame_start
    lat = 6;
    pop_check("t3", DEPTH);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_mem);
      pix_pop = 1'b1;
    end
    @(negedge clk_mem);
    pix_pop = 1'b0;
    check_eq("t3_underflow_set", 32'(underflow), 32'd1);
`ifdef BG_UNDERFLOW_STATS_EN
    check_eq("t3_underflow_cnt_nz", 32'(underflow_cnt != 16'd0), 32'd1);
`endif
    pulse_frame();
    check_eq("t3_underflow_clr", 32'(underflow), 32'd0);

    // 4: frame_start while the read of 0x10 is in flight
    tick(200);
    mark = rd_log.size();
    pulse_pop();
    wait_rd("t4", mark);
    if (rd_log.size() > mark) check_eq("t4_inflight_addr", 32'(rd_log[mark]), 32'h10);
    pulse_frame();
    tick(200);
    check_eq("t4_next_rd_exists", 32'(rd_log.size() > mark + 1), 32'd1);
    if (rd_log.size() > mark + 1) check_eq("t4_next_rd_addr", 32'(rd_log[mark + 1]), 32'd0);
    pop_check("t4", DEPTH);

    // 5: write arriving while a read waits on sd_ready goes first
    tick(200);
    force_busy = 1'b1;
    tick(3);
    mark = ev_is_we.size();
    pulse_pop();
    tick(3);
    dl_write(AW'(16'h100), 8'h3C);
    tick(3);
    force_busy = 1'b0;
    tick(100);
    check_eq("t5_events", 32'(ev_is_we.size() >= mark + 2), 32'd1);
    if (ev_is_we.size() >= mark + 2) begin
      check_eq("t5_first_is_we", 32'(ev_is_we[mark]), 32'd1);
      check_eq("t5_we_addr", 32'(ev_addr[mark]), 32'h100);
      check_eq("t5_second_is_rd", 32'(ev_is_we[mark + 1]), 32'd0);
    end
    if (we_data_log.size() > 0) check_eq("t5_we_data", 32'(we_data_log[$]), 32'h3C);
    check_eq("t5_no_drop", 32'(dut.drop_q), 32'd0);

    // 6: fetch address wraps at FRAME_BYTES
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_mem);
      pix_pop = 1'b1;
    end
    @(negedge clk_mem);
    pix_pop = 1'b0;
    tick(300);
    found = 0;
    for (int i = 0; i + 1 < rd_log.size(); i++) begin
      if (rd_log[i] == AW'(FRAME - 2)) begin
        found = 1;
        check_eq("t6_wrap_addr", 32'(rd_log[i + 1]), 32'd0);
      end
    end
    check_eq("t6_wrap_seen", 32'(found), 32'd1);
    check_eq("strobe_while_busy", 32'(strobe_err), 32'd0);
    check_eq("total_we", 32'(we_addr_log.size()), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
